// File: rtl/maze_map_latch.sv
// maze_map_latch: samples the LFSR wall words, forces the start/goal cells
// open and holds the result as a stable maze map for the VGA renderer.
// A map is regenerated when its hold time expires or when the game asks for
// a new one over a 4-phase req/ack handshake.
//
// Handshake: regen_req is level-held by the requester. A request is taken
// only in HOLD while regen_ack is 0. regen_ack rises on the edge that loads
// the new map, stays 1 while regen_req is 1, and falls on the first edge
// where regen_req is 0.
//
// Wall bits are active-low: 0 = wall drawn, 1 = open.
module maze_map_latch #(
    parameter int                 N_CELLS   = 25,
    parameter int                 HOLD_SECS = 5,
    parameter int                 RETRY_MAX = 3,
    parameter int                 LVL_W     = 4,
    parameter logic [N_CELLS:0]   OPEN_H    = 'h1,
    parameter logic [N_CELLS:0]   OPEN_V    = 'h1
) (
    input  logic               sec_clock,
    input  logic               reset,
    input  logic [N_CELLS:0]   rand_h,
    input  logic [N_CELLS:0]   rand_v,
    input  logic               freeze,
    input  logic               regen_req,
    output logic               regen_ack,
    output logic [N_CELLS:0]   wall_h,
    output logic [N_CELLS:0]   wall_v,
    output logic               map_valid,
    output logic [LVL_W-1:0]   level,
    output logic [3:0]         secs_left,
    output logic [1:0]         state_dbg
);

    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [3:0]    SECS_RELOAD = 4'(HOLD_SECS - 1);
    localparam logic [RW-1:0] RETRY_LIM   = RW'(RETRY_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [N_CELLS:0]   wall_h_q,    wall_h_d;
    logic [N_CELLS:0]   wall_v_q,    wall_v_d;
    logic [N_CELLS:0]   prev_h_q,    prev_h_d;
    logic [N_CELLS:0]   prev_v_q,    prev_v_d;
    logic               map_valid_q, map_valid_d;
    logic               regen_ack_q, regen_ack_d;
    logic               pending_q,   pending_d;
    logic [LVL_W-1:0]   level_q,     level_d;
    logic [3:0]         secs_left_q, secs_left_d;
    logic [RW-1:0]      retry_q,     retry_d;

    logic               repeat_raw;

    // Same raw words as the map currently shown: resample instead of reusing.
    assign repeat_raw = (rand_h == prev_h_q) && (rand_v == prev_v_q);

    // Next-state and datapath updates for the IDLE/LOAD/HOLD sequencer.
    always_comb begin
        state_d     = state_q;
        wall_h_d    = wall_h_q;
        wall_v_d    = wall_v_q;
        prev_h_d    = prev_h_q;
        prev_v_d    = prev_v_q;
        map_valid_d = map_valid_q;
        regen_ack_d = regen_ack_q;
        pending_d   = pending_q;
        level_d     = level_q;
        secs_left_d = secs_left_q;
        retry_d     = retry_q;

        // Ack release follows the request dropping, in any state.
        if (!regen_req) begin
            regen_ack_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                if (repeat_raw && (retry_q < RETRY_LIM)) begin
                    retry_d = retry_q + 1'b1;
                end else begin
                    prev_h_d    = rand_h;
                    prev_v_d    = rand_v;
                    wall_h_d    = rand_h | OPEN_H;
                    wall_v_d    = rand_v | OPEN_V;
                    map_valid_d = 1'b1;
                    secs_left_d = SECS_RELOAD;
                    retry_d     = '0;
                    state_d     = ST_HOLD;
                    if (pending_q) begin
                        regen_ack_d = 1'b1;
                        pending_d   = 1'b0;
                        if (level_q != {LVL_W{1'b1}}) begin
                            level_d = level_q + 1'b1;
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (regen_req && !regen_ack_q) begin
                    pending_d = 1'b1;
                    state_d   = ST_LOAD;
                end else if ((secs_left_q == 4'd0) && !freeze) begin
                    state_d = ST_LOAD;
                end else if (!freeze) begin
                    secs_left_d = secs_left_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge sec_clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wall_h_q    <= '1;
            wall_v_q    <= '1;
            prev_h_q    <= '0;
            prev_v_q    <= '0;
            map_valid_q <= 1'b0;
            regen_ack_q <= 1'b0;
            pending_q   <= 1'b0;
            level_q     <= '0;
            secs_left_q <= 4'd0;
            retry_q     <= '0;
        end else begin
            state_q     <= state_d;
            wall_h_q    <= wall_h_d;
            wall_v_q    <= wall_v_d;
            prev_h_q    <= prev_h_d;
            prev_v_q    <= prev_v_d;
            map_valid_q <= map_valid_d;
            regen_ack_q <= regen_ack_d;
            pending_q   <= pending_d;
            level_q     <= level_d;
            secs_left_q <= secs_left_d;
            retry_q     <= retry_d;
        end
    end

    assign wall_h    = wall_h_q;
    assign wall_v    = wall_v_q;
    assign map_valid = map_valid_q;
    assign regen_ack = regen_ack_q;
    assign level     = level_q;
    assign secs_left = secs_left_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_maze_map_latch.sv
// Bench for maze_map_latch: a table of per-edge vectors covering reset,
// auto-regen with retries and the request handshake, followed by
// hand-written sequences for freeze, request-at-timeout, level saturation
// and reset during a retry.
module tb_maze_map_latch;

    localparam logic [25:0] H0 = 26'h2AAAAAA;
    localparam logic [25:0] V0 = 26'h1555554;
    localparam logic [25:0] H1 = 26'h0F0F0F0;
    localparam logic [25:0] V1 = 26'h3000000;
    localparam logic [25:0] MA = 26'h2AAAAAB; // H0 with cell 0 opened
    localparam logic [25:0] MB = 26'h1555555; // V0 with cell 0 opened
    localparam logic [25:0] MC = 26'h0F0F0F1; // H1 with cell 0 opened
    localparam logic [25:0] MD = 26'h3000001; // V1 with cell 0 opened
    localparam logic [25:0] RW = 26'h3FFFFFF; // no walls
    localparam logic [1:0]  SI = 2'd0;
    localparam logic [1:0]  SL = 2'd1;
    localparam logic [1:0]  SH = 2'd2;

    logic        sec_clock;
    logic        reset;
    logic [25:0] rand_h;
    logic [25:0] rand_v;
    logic        freeze;
    logic        regen_req;
    logic        regen_ack;
    logic [25:0] wall_h;
    logic [25:0] wall_v;
    logic        map_valid;
    logic [3:0]  level;
    logic [3:0]  secs_left;
    logic [1:0]  state_dbg;

    int n_tests;
    int n_fail;

    typedef struct packed {
        logic        rst;
        logic [25:0] rh;
        logic [25:0] rv;
        logic        frz;
        logic        req;
        logic [25:0] e_wh;
        logic [25:0] e_wv;
        logic        e_valid;
        logic        e_ack;
        logic [3:0]  e_lvl;
        logic [3:0]  e_secs;
        logic [1:0]  e_st;
    } vec_t;

    vec_t vecs[24];

    maze_map_latch dut (
        .sec_clock (sec_clock),
        .reset     (reset),
        .rand_h    (rand_h),
        .rand_v    (rand_v),
        .freeze    (freeze),
        .regen_req (regen_req),
        .regen_ack (regen_ack),
        .wall_h    (wall_h),
        .wall_v    (wall_v),
        .map_valid (map_valid),
        .level     (level),
        .secs_left (secs_left),
        .state_dbg (state_dbg)
    );

    // Clock and reset block
    initial sec_clock = 1'b0;
    always #5 sec_clock = ~sec_clock;

    function automatic vec_t mk(input logic rst, input logic [25:0] rh, input logic [25:0] rv,
                                input logic frz, input logic req,
                                input logic [25:0] e_wh, input logic [25:0] e_wv,
                                input logic e_valid, input logic e_ack,
                                input logic [3:0] e_lvl, input logic [3:0] e_secs,
                                input logic [1:0] e_st);
        vec_t v;
        v = '{rst, rh, rv, frz, req, e_wh, e_wv, e_valid, e_ack, e_lvl, e_secs, e_st};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One active edge, outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge sec_clock);
        #1;
    endtask

    task automatic drive(input logic rst, input logic [25:0] rh, input logic [25:0] rv,
                         input logic frz, input logic req);
        reset     = rst;
        rand_h    = rh;
        rand_v    = rv;
        freeze    = frz;
        regen_req = req;
    endtask

    task automatic chk_all(input string tag, input logic [25:0] e_wh, input logic [25:0] e_wv,
                           input logic e_valid, input logic e_ack, input logic [3:0] e_lvl,
                           input logic [3:0] e_secs, input logic [1:0] e_st);
        chk({tag, ".wall_h"},    32'(wall_h),    32'(e_wh));
        chk({tag, ".wall_v"},    32'(wall_v),    32'(e_wv));
        chk({tag, ".map_valid"}, 32'(map_valid), 32'(e_valid));
        chk({tag, ".regen_ack"}, 32'(regen_ack), 32'(e_ack));
        chk({tag, ".level"},     32'(level),     32'(e_lvl));
        chk({tag, ".secs_left"}, 32'(secs_left), 32'(e_secs));
        chk({tag, ".state"},     32'(state_dbg), 32'(e_st));
    endtask

    initial begin
        logic [3:0] exp_lvl;
        n_tests = 0;
        n_fail  = 0;

        // Reset, first map, auto-regen with three resamples, request handshake.
        vecs[0]  = mk(0, H0, V0, 0, 0, RW, RW, 0, 0, 0, 0, SI);
        vecs[1]  = mk(0, H0, V0, 0, 0, RW, RW, 0, 0, 0, 0, SI);
        vecs[2]  = mk(0, H0, V0, 0, 0, RW, RW, 0, 0, 0, 0, SI);
        vecs[3]  = mk(1, H0, V0, 0, 0, RW, RW, 0, 0, 0, 0, SL);
        vecs[4]  = mk(1, H0, V0, 0, 0, MA, MB, 1, 0, 0, 4, SH);
        vecs[5]  = mk(1, H0, V0, 0, 0, MA, MB, 1, 0, 0, 3, SH);
        vecs[6]  = mk(1, H0, V0, 0, 0, MA, MB, 1, 0, 0, 2, SH);
        vecs[7]  = mk(1, H0, V0, 0, 0, MA, MB, 1, 0, 0, 1, SH);
        vecs[8]  = mk(1, H0, V0, 0, 0, MA, MB, 1, 0, 0, 0, SH);
        vecs[9]  = mk(1, H0, V0, 0, 0, MA, MB, 1, 0, 0, 0, SL);
        vecs[10] = mk(1, H0, V0, 0, 0, MA, MB, 1, 0, 0, 0, SL);
        vecs[11] = mk(1, H0, V0, 0, 0, MA, MB, 1, 0, 0, 0, SL);
        vecs[12] = mk(1, H0, V0, 0, 0, MA, MB, 1, 0, 0, 0, SL);
        vecs[13] = mk(1, H0, V0, 0, 0, MA, MB, 1, 0, 0, 4, SH);
        vecs[14] = mk(1, H1, V1, 0, 1, MA, MB, 1, 0, 0, 4, SL);
        vecs[15] = mk(1, H1, V1, 0, 1, MC, MD, 1, 1, 1, 4, SH);
        vecs[16] = mk(1, H1, V1, 0, 1, MC, MD, 1, 1, 1, 3, SH);
        vecs[17] = mk(1, H1, V1, 0, 1, MC, MD, 1, 1, 1, 2, SH);
        vecs[18] = mk(1, H1, V1, 0, 1, MC, MD, 1, 1, 1, 1, SH);
        vecs[19] = mk(1, H1, V1, 0, 1, MC, MD, 1, 1, 1, 0, SH);
        vecs[20] = mk(1, H0, V0, 0, 0, MC, MD, 1, 0, 1, 0, SL);
        vecs[21] = mk(1, H0, V0, 0, 0, MA, MB, 1, 0, 1, 4, SH);
        vecs[22] = mk(1, H0, V0, 0, 0, MA, MB, 1, 0, 1, 3, SH);
        vecs[23] = mk(1, H0, V0, 0, 0, MA, MB, 1, 0, 1, 2, SH);

        drive(0, H0, V0, 0, 0);
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rst, vecs[i].rh, vecs[i].rv, vecs[i].frz, vecs[i].req);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_wh, vecs[i].e_wv, vecs[i].e_valid,
                    vecs[i].e_ack, vecs[i].e_lvl, vecs[i].e_secs, vecs[i].e_st);
        end

        // Freeze with two seconds left: countdown and map hold still.
        drive(1, H1, V1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("frz%0d.secs_left", i), 32'(secs_left), 32'd2);
            chk($sformatf("frz%0d.wall_h", i),    32'(wall_h),    32'(MA));
        end
        freeze = 1'b0;
        step();
        chk("unfrz1.secs_left", 32'(secs_left), 32'd1);
        step();
        chk("unfrz2.secs_left", 32'(secs_left), 32'd0);
        step();
        chk("unfrz3.state", 32'(state_dbg), 32'(SL));
        step();
        chk_all("unfrz4", MC, MD, 1, 0, 1, 4, SH);

        // Request on the edge the hold time runs out: one reload, one level.
        for (int i = 0; i < 4; i++) step();
        chk("to.secs_left", 32'(secs_left), 32'd0);
        drive(1, H0, V0, 0, 1);
        step();
        chk_all("to_req1", MC, MD, 1, 0, 1, 0, SL);
        step();
        chk_all("to_req2", MA, MB, 1, 1, 2, 4, SH);
        regen_req = 1'b0;
        step();
        chk_all("to_req3", MA, MB, 1, 0, 2, 3, SH);

        // Sixteen more requests: level saturates at 15.
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) drive(1, H1, V1, 0, 1);
            else            drive(1, H0, V0, 0, 1);
            exp_lvl = (3 + k > 15) ? 4'd15 : 4'(3 + k);
            step();
            chk($sformatf("sat%0d.state_load", k), 32'(state_dbg), 32'(SL));
            step();
            chk_all($sformatf("sat%0d.ack", k), (k % 2 == 0) ? MC : MA, (k % 2 == 0) ? MD : MB,
                    1, 1, exp_lvl, 4, SH);
            regen_req = 1'b0;
            step();
            chk($sformatf("sat%0d.ack_drop", k), 32'(regen_ack), 32'd0);
        end

        // Reset while LOAD is retrying a repeated word: pending ack is lost.
        drive(1, H0, V0, 0, 1);
        step();
        chk("rst_mid.load", 32'(state_dbg), 32'(SL));
        step();
        chk_all("rst_mid.retry", MA, MB, 1, 0, 15, 3, SL);
        reset = 1'b0;
        step();
        chk_all("rst_mid.reset", RW, RW, 0, 0, 0, 0, SI);
        reset = 1'b1;
        step();
        chk_all("rst_mid.rel1", RW, RW, 0, 0, 0, 0, SL);
        step();
        chk_all("rst_mid.rel2", MA, MB, 1, 0, 0, 4, SH);
        regen_req = 1'b0;
        step();
        chk_all("rst_mid.rel3", MA, MB, 1, 0, 0, 3, SH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
